// File: rtl/pls_gen_pkg.sv
// Shared watch package: FSM state encoding, clog2 helper and default pulse dividers.
package pls_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Default dividers assume a 50 MHz system clock.
  localparam int unsigned      DIV_SEC_DEF  = 50_000_000;
  localparam longint unsigned  DIV_MIN_DEF  = 64'd3_000_000_000;
  localparam longint unsigned  DIV_HOUR_DEF = 64'd180_000_000_000;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pls_gen_if.sv
// Control/status bundle between a pulse-train user and pls_gen.
interface pls_gen_if #(
  parameter int unsigned NW = 6
);
  logic          clr;
  logic          run;
  logic          burst_req;
  logic [NW-1:0] burst_n;
  logic          plso;
  logic          tick;
  logic          busy;
  logic          done;

  modport master (
    output clr, run, burst_req, burst_n,
    input  plso, tick, busy, done
  );

  modport slave (
    input  clr, run, burst_req, burst_n,
    output plso, tick, busy, done
  );
endinterface

// File: rtl/pls_phase_div.sv
// Phase counter: one period of P cycles, H = P/2 high then low; P chosen by sel_burst.
module pls_phase_div
  import pls_gen_pkg::*;
#(
  parameter int unsigned DIV       = 10,
  parameter int unsigned BURST_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_stop,
  input  logic i_active,
  input  logic i_sel_burst,
  output logic o_fall_c,
  output logic o_eop_c,
  output logic o_plso
);

  localparam int unsigned CW = clog2((DIV > BURST_DIV) ? DIV : BURST_DIV);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_fall_at;
  logic [CW-1:0] w_eop_at;

  assign w_fall_at = i_sel_burst ? CW'(BURST_DIV / 2 - 1) : CW'(DIV / 2 - 1);
  assign w_eop_at  = i_sel_burst ? CW'(BURST_DIV - 1)     : CW'(DIV - 1);
  assign o_fall_c  = i_active & (r_cnt == w_fall_at);
  assign o_eop_c   = i_active & (r_cnt == w_eop_at);

  // stop beats load; the owner always issues one of them at end of period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      o_plso <= 1'b0;
    end else if (i_stop) begin
      r_cnt  <= '0;
      o_plso <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= '0;
      o_plso <= 1'b1;
    end else if (i_active) begin
      if (o_fall_c) o_plso <= 1'b0;
      r_cnt <= o_eop_c ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pls_gen.sv
// Pulse-train source: free-running RUN periods or counted fast BURST pulses, clr aborts.
module pls_gen
  import pls_gen_pkg::*;
#(
  parameter int unsigned DIV       = DIV_SEC_DEF,
  parameter int unsigned BURST_DIV = 16,
  parameter int unsigned NW        = 6
) (
  input  logic      clk,
  input  logic      rst,
  pls_gen_if.slave  bus
);

  state_t        r_state;
  state_t        w_nxt;
  logic          r_clr_d;
  logic          r_pend;
  logic [NW-1:0] r_n;
  logic [NW-1:0] r_rem;
  logic          r_tick;
  logic          r_busy;
  logic          r_done;
  logic          w_clr_edge;
  logic          w_req_ok;
  logic          w_load;
  logic          w_stop;
  logic          w_fall_c;
  logic          w_eop_c;
  logic          w_plso;

  assign w_clr_edge = bus.clr & ~r_clr_d;
  assign w_req_ok   = bus.burst_req & (bus.burst_n != '0);

  pls_phase_div #(
    .DIV       (DIV),
    .BURST_DIV (BURST_DIV)
  ) u_phase (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_stop      (w_stop),
    .i_active    (r_state != ST_IDLE),
    .i_sel_burst (r_state == ST_BURST),
    .o_fall_c    (w_fall_c),
    .o_eop_c     (w_eop_c),
    .o_plso      (w_plso)
  );

  // Transition decision; a period is only ever ended at its EOP unless clr aborts it.
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_stop = 1'b0;
    if (w_clr_edge) begin
      w_nxt  = ST_IDLE;
      w_stop = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pend || w_req_ok) begin
            w_nxt  = ST_BURST;
            w_load = 1'b1;
          end else if (bus.run) begin
            w_nxt  = ST_RUN;
            w_load = 1'b1;
          end
        end
        ST_RUN: begin
          if (w_eop_c) begin
            if (r_pend) begin
              w_nxt  = ST_BURST;
              w_load = 1'b1;
            end else if (bus.run) begin
              w_load = 1'b1;
            end else begin
              w_nxt  = ST_IDLE;
              w_stop = 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (w_eop_c) begin
            if (r_rem != NW'(1)) begin
              w_load = 1'b1;
            end else if (bus.run) begin
              w_nxt  = ST_RUN;
              w_load = 1'b1;
            end else begin
              w_nxt  = ST_IDLE;
              w_stop = 1'b1;
            end
          end
        end
        default: begin
          w_nxt  = ST_IDLE;
          w_stop = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_clr_d <= 1'b0;
      r_pend  <= 1'b0;
      r_n     <= '0;
      r_rem   <= '0;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_clr_d <= bus.clr;
      r_state <= w_nxt;
      r_busy  <= (w_nxt == ST_BURST);
      r_tick  <= w_fall_c & ~w_clr_edge;
      r_done  <= 1'b0;
      if (w_clr_edge) begin
        r_pend <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_pend)                r_rem  <= r_n;
            else if (w_req_ok)         r_rem  <= bus.burst_n;
            else if (bus.burst_req)    r_done <= 1'b1;
          end
          ST_RUN: begin
            if (w_eop_c && r_pend) begin
              r_rem <= r_n;
            end else if (bus.burst_req && !r_pend) begin
              if (w_req_ok) begin
                r_pend <= 1'b1;
                r_n    <= bus.burst_n;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_BURST: begin
            if (w_eop_c) begin
              if (r_rem == NW'(1)) begin
                r_done <= 1'b1;
                r_pend <= 1'b0;
              end else begin
                r_rem <= r_rem - NW'(1);
              end
            end
          end
          default: r_pend <= 1'b0;
        endcase
      end
    end
  end

  assign bus.plso = w_plso;
  assign bus.tick = r_tick;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_pls_gen.sv
// Bench for pls_gen: table vectors, directed corner sequences and random traffic vs a waveform-queue model.
module tb_pls_gen;

  localparam int unsigned NW     = 6;
  localparam int          DIV_T  = 10;
  localparam int          BDIV_T = 4;
  localparam int          M_IDLE  = 0;
  localparam int          M_RUN   = 1;
  localparam int          M_BURST = 2;

  typedef struct {
    bit       c;
    bit       r;
    bit       q;
    int       n;
    bit [3:0] e;   // {plso, tick, busy, done} seen the cycle after the inputs
  } vec_t;

  logic clk;
  logic rst;

  pls_gen_if #(.NW(NW)) bus ();

  pls_gen #(
    .DIV       (DIV_T),
    .BURST_DIV (BDIV_T),
    .NW        (NW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int cyc;
  vec_t tbl[$];

  // Model: queue of the plso samples still to come in the current period.
  bit mq[$];
  int m_mode;
  int m_pend;
  int m_pn;
  int m_left;
  bit m_clr_prev;
  bit m_plso;
  bit m_tick;
  bit m_busy;
  bit m_done;

  function automatic void add(bit c, bit r, bit q, int n, bit [3:0] e);
    vec_t v;
    v.c = c; v.r = r; v.q = q; v.n = n; v.e = e;
    tbl.push_back(v);
  endfunction

  function automatic void push_period(int p);
    for (int k = 0; k < p; k++) mq.push_back(k < p / 2);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_mode = M_IDLE; m_pend = 0; m_pn = 0; m_left = 0;
    m_clr_prev = 1'b0;
    m_plso = 1'b0; m_tick = 1'b0; m_busy = 1'b0; m_done = 1'b0;
  endfunction

  function automatic void start_burst(int n);
    m_mode = M_BURST;
    m_left = n;
    push_period(BDIV_T);
  endfunction

  function automatic void start_run();
    m_mode = M_RUN;
    push_period(DIV_T);
  endfunction

  function automatic void model_edge(bit c, bit r, bit q, int n);
    bit cur;
    bit eop;
    int pend0;
    cur    = m_plso;
    pend0  = m_pend;
    eop    = 1'b0;
    m_done = 1'b0;
    if (c && !m_clr_prev) begin
      m_clr_prev = c;
      mq.delete();
      m_mode = M_IDLE; m_pend = 0;
      m_plso = 1'b0; m_tick = 1'b0; m_busy = 1'b0;
      return;
    end
    m_clr_prev = c;
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      eop = (mq.size() == 0);
    end
    if (m_mode == M_IDLE) begin
      if (m_pend != 0)           start_burst(m_pn);
      else if (q && n != 0)      start_burst(n);
      else begin
        if (q) m_done = 1'b1;
        if (r) start_run();
      end
    end else if (m_mode == M_RUN) begin
      if (eop) begin
        if (pend0 != 0) start_burst(m_pn);
        else if (r)     start_run();
        else            m_mode = M_IDLE;
      end
      if (pend0 == 0 && q) begin
        if (n == 0) m_done = 1'b1;
        else begin m_pend = 1; m_pn = n; end
      end
    end else if (eop) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_pend = 0;
        if (r) start_run();
        else   m_mode = M_IDLE;
      end else begin
        push_period(BDIV_T);
      end
    end
    m_plso = (mq.size() > 0) ? mq[0] : 1'b0;
    m_tick = cur && !m_plso;
    m_busy = (m_mode == M_BURST);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input bit c, input bit r, input bit q, input int n);
    bus.clr = c; bus.run = r; bus.burst_req = q; bus.burst_n = NW'(n);
    @(posedge clk);
    model_edge(c, r, q, n);
    @(negedge clk);
    cyc++;
    chk("model_plso", bus.plso, m_plso);
    chk("model_tick", bus.tick, m_tick);
    chk("model_busy", bus.busy, m_busy);
    chk("model_done", bus.done, m_done);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_mode != M_IDLE || mq.size() != 0 || m_pend != 0) && k < 200) begin
      step(1'b0, 1'b0, 1'b0, 0);
      k++;
    end
    if (k >= 200) begin
      n_total++;
      $display("FAIL drain: no return to idle within %0d cycles", k);
    end
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ticks, t2, highs, cnt60, wraps, dones;
    bit prev, c, r, q;
    int n;
    logic rp[1:28];
    logic rb[1:28];
    logic rd[1:28];
    int bsy, first_b, dcnt, h1, h2, h3;
    logic p6, b6, d6, p7;

    n_pass = 0; n_total = 0; cyc = 0;
    model_reset();
    rst = 1'b1;
    bus.clr = 1'b0; bus.run = 1'b0; bus.burst_req = 1'b0; bus.burst_n = '0;

    // burst of 3 from idle, then a zero-length request
    add(0, 0, 1, 3, 4'b1010);
    add(0, 0, 0, 0, 4'b1010);
    add(0, 0, 0, 0, 4'b0110);
    add(0, 0, 0, 0, 4'b0010);
    add(0, 0, 0, 0, 4'b1010);
    add(0, 0, 0, 0, 4'b1010);
    add(0, 0, 0, 0, 4'b0110);
    add(0, 0, 0, 0, 4'b0010);
    add(0, 0, 0, 0, 4'b1010);
    add(0, 0, 0, 0, 4'b1010);
    add(0, 0, 0, 0, 4'b0110);
    add(0, 0, 0, 0, 4'b0010);
    add(0, 0, 0, 0, 4'b0001);
    add(0, 0, 1, 0, 4'b0001);
    add(0, 0, 0, 0, 4'b0000);
    add(0, 0, 0, 0, 4'b0000);

    repeat (3) @(negedge clk);
    chk("rst_plso", bus.plso, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);

    // free-running 5 high / 5 low, then run dropped at cnt==2
    ticks = 0; highs = 0;
    for (int i = 0; i < 103; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      if (i == 0) chk("run_first_plso", bus.plso, 1);
      if (i == 5) chk("run_first_tick", bus.tick, 1);
      if (i < 100) ticks += int'(bus.tick);
      else         highs += int'(bus.plso);
    end
    chk("run_ticks_100", ticks, 10);
    t2 = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      highs += int'(bus.plso);
      t2 += int'(bus.tick);
    end
    chk("drop_high_cycles", highs, 5);
    chk("drop_ticks", t2, 1);
    chk("drop_idle_plso", bus.plso, 0);
    drain();

    // downstream mod-60 counter on falling edges
    cnt60 = 0; wraps = 0; prev = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      if (prev && !bus.plso) begin
        cnt60 = (cnt60 + 1) % 60;
        if (cnt60 == 0) wraps++;
      end
      prev = bus.plso;
    end
    chk("mod60_value", cnt60, 0);
    chk("mod60_wraps", wraps, 1);
    drain();

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].r, tbl[i].q, tbl[i].n);
      chk($sformatf("tbl%0d_plso", i), bus.plso, tbl[i].e[3]);
      chk($sformatf("tbl%0d_tick", i), bus.tick, tbl[i].e[2]);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e[1]);
      chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].e[0]);
    end

    // burst request at cnt==3 in RUN: period completes, 2 bursts, RUN resumes
    for (int i = 0; i < 28; i++) begin
      step(1'b0, 1'b1, (i == 4), (i == 4) ? 2 : 0);
      rp[i+1] = bus.plso; rb[i+1] = bus.busy; rd[i+1] = bus.done;
    end
    bsy = 0; first_b = 0; dcnt = 0; h1 = 0; h2 = 0; h3 = 0;
    for (int k = 1; k <= 28; k++) begin
      if (rb[k] === 1'b1) begin bsy++; if (first_b == 0) first_b = k; end
      if (rd[k] === 1'b1) dcnt++;
      if (k <= 10 && rp[k] === 1'b1) h1++;
      if (k >= 19 && k <= 23 && rp[k] === 1'b1) h2++;
      if (k >= 24 && rp[k] === 1'b1) h3++;
    end
    chk("rb_first_period_high", h1, 5);
    chk("rb_busy_cycles", bsy, 8);
    chk("rb_busy_start", first_b, 11);
    chk("rb_done_at_19", rd[19], 1);
    chk("rb_done_count", dcnt, 1);
    chk("rb_resume_high", h2, 5);
    chk("rb_resume_low", h3, 0);
    drain();

    // clr during the 2nd pulse of a 5-burst, run raised with it
    ticks = 0; dones = 0;
    p6 = 1'b0; b6 = 1'b0; d6 = 1'b0; p7 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step((i >= 5 && i < 9), (i >= 5), (i == 0), (i == 0) ? 5 : 0);
      if (i <= 5) ticks += int'(bus.tick);
      dones += int'(bus.done);
      if (i == 5) begin p6 = bus.plso; b6 = bus.busy; d6 = bus.done; end
      if (i == 6) p7 = bus.plso;
    end
    chk("clr_plso_next", p6, 0);
    chk("clr_busy_next", b6, 0);
    chk("clr_no_done", d6, 0);
    chk("clr_done_total", dones, 0);
    chk("clr_ticks", ticks, 1);
    chk("clr_run_restart", p7, 1);
    drain();

    // random traffic against the model
    c = 1'b0; r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r = !r;
      q = ($urandom_range(0, 15) == 0);
      n = int'($urandom_range(0, 5));
      if ($urandom_range(0, 149) == 0) c = 1'b1;
      else if ($urandom_range(0, 3) == 0) c = 1'b0;
      step(c, r, q, n);
    end
    step(1'b0, 1'b0, 1'b0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pls_gen.md
Name: pls_gen

Overview:
- Pulse-train source for the watch counter chain; drives the `plsi` input of the mod-N pulse counters.
- Free-running mode emits one 50 % pulse per DIV clocks, for example a 1 Hz seconds source.
- Burst mode emits a programmed number of fast pulses, used by time-setting to advance minutes or hours by N steps.
- Each emitted pulse ends in exactly one falling edge, which is the edge the downstream counters count.

Parameters:
- DIV, 50000000: clk cycles per free-running pulse period; must be >= 2.
- BURST_DIV, 16: clk cycles per burst pulse period; must be >= 2.
- NW, 6: width of the burst count.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-high; clock clk.
- clr  input  1  synchronous abort request; acts on its rising edge.
- run  input  1  level; enables free-running pulse generation.
- burst_req  input  1  single-cycle strobe; request a burst.
- burst_n  input  NW  number of burst pulses; sampled when burst_req is accepted.
- plso  output  1  registered pulse train to the counter's `plsi`.
- tick  output  1  single-cycle strobe on the first cycle `plso` reads 0 after a high phase.
- busy  output  1  high while in BURST.
- done  output  1  single-cycle strobe when a burst completes normally.

Behaviour:
- Reset values: `plso`, `tick`, `busy` and `done` are 0; state is IDLE; phase counter is 0; pending flag is 0.
- Period P = DIV in RUN and BURST_DIV in BURST.
  - High phase H = floor(P/2) cycles; low phase L = P-H cycles.
- Phase counter cnt runs 0..P-1.
  - Entering RUN or BURST: cnt<=0 and plso<=1.
  - At cnt==H-1: plso<=0 and tick<=1 for one cycle.
  - At cnt==P-1: end of period (EOP).
- States:
  - IDLE: plso=0. If burst_req and burst_n!=0, go to BURST next cycle. Else if run, go to RUN. burst_req with burst_n==0: done=1 next cycle, state unchanged, busy stays 0.
  - RUN: free-running periods.
    - burst_req sets pending and latches burst_n (n==0: done next cycle, no pending).
    - At EOP: if pending, go to BURST. Else if !run, go to IDLE. Else start next period.
    - A run drop mid-period never truncates a pulse.
  - BURST: busy=1. remaining counter loaded with the latched n; decrements at each EOP.
    - At the EOP where remaining==1: done<=1 and pending<=0, then go to RUN if run else IDLE.
    - Further burst_req in BURST is ignored.
- clr:
  - Rising edge is detected against a one-cycle delayed copy.
  - Takes effect in any state: next cycle plso=0, tick=0, busy=0, cnt=0, pending=0, state IDLE. done is not asserted.
  - If run is still 1, RUN restarts the following cycle.
- Priority in one cycle: clr edge > EOP transition > burst_req.
  - burst_req coincident with a clr edge is dropped.
- Latency:
  - burst_req in IDLE gives plso=1 on the next cycle.
  - run rising in IDLE gives plso=1 on the next cycle.
- Tick count per burst equals n exactly. plso never produces a high or low phase shorter than its nominal length, except when aborted by clr.
- Counter width is clog2(max(DIV, BURST_DIV)). No arithmetic overflow is possible.

Decomposition:
- Shared watch package holds:
  - State encoding constants: ST_IDLE, ST_RUN, ST_BURST.
  - The clog2 function.
  - Default DIV constants for seconds, minutes and hours.
- One natural sub-module, `pls_phase_div`:
  - Inputs: load (restart), sel_burst (choose P).
  - Outputs: cnt, fall strobe, eop strobe, registered plso.
  - The FSM, pending logic and burst counter stay in `pls_gen`.

Test Plan (DIV=10, BURST_DIV=4):
1. Reset release, then run=1 at cycle 0 → plso is 1 for cycles 1-5 and 0 for cycles 6-10, repeating. tick is high at cycles 6, 16, 26. After 100 cycles, 10 ticks.
2. IDLE, burst_req with burst_n=3 → plso pattern 1,1,0,0 ×3. busy high for 12 cycles. done is 1 in the cycle after the last low cycle. Exactly 3 ticks; state returns to IDLE.
3. burst_req with burst_n=0 in IDLE → done=1 next cycle. plso and busy stay 0 and no tick.
4. RUN, burst_req at cnt=3 with n=2 → current 10-cycle period completes, then 2 bursts of 4 cycles, then done. RUN resumes with full 5-high/5-low periods.
5. clr rising during the 2nd pulse of an n=5 burst → next cycle plso=0, busy=0, no done, total ticks=1. With run=1, RUN restarts one cycle later.
6. run dropped at cnt=2 in RUN → pulse finishes its 5-high/5-low period, then plso stays 0 and no further tick. Feeding plso to a mod-60 counter with run=1 for 600 cycles → counter wraps to 0 exactly once.
